// File: rtl/cache_write_buffer_pkg.sv
// Shared definitions for the cache / write-buffer / memory path.
//   ADDR_W, DATA_W : line address and line data widths, common to the cache
//   WB_DEPTH       : default number of posted writeback entries
//   c_state_e      : cache-side handshake states
//   m_state_e      : memory-side drain/fetch states
package cache_pkg;
    localparam int ADDR_W   = 28;
    localparam int DATA_W   = 128;
    localparam int WB_DEPTH = 4;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_RDMEM = 2'd1,
        C_ACK   = 2'd2
    } c_state_e;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_WR   = 2'd1,
        M_RD   = 2'd2
    } m_state_e;
endpackage

// File: rtl/cache_write_buffer_if.sv
// Bus bundles around the write buffer.
//   cwb_cache_if : cache line port. master = cache, slave = write buffer.
//                  c_read/c_write/c_addr/c_wdata towards buffer, c_rdata/c_ready back.
//   cwb_mem_if   : memory line port. master = write buffer, slave = memory.
//                  mem_read/mem_write/mem_addr/mem_wdata towards memory,
//                  mem_rdata/mem_ready back.
interface cwb_cache_if #(
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int DATA_W = cache_pkg::DATA_W
);
    logic              c_read;
    logic              c_write;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              c_ready;

    modport master (output c_read, c_write, c_addr, c_wdata, input c_rdata, c_ready);
    modport slave  (input c_read, c_write, c_addr, c_wdata, output c_rdata, c_ready);
endinterface

interface cwb_mem_if #(
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int DATA_W = cache_pkg::DATA_W
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (output mem_read, mem_write, mem_addr, mem_wdata, input mem_rdata, mem_ready);
    modport slave  (input mem_read, mem_write, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/cache_write_buffer_fifo.sv
// wbuf_fifo: DEPTH-entry circular store of posted writebacks with an address CAM.
//   clk, rst          : clock, synchronous active-high reset (empties the store)
//   push_i            : append {push_addr_i, push_data_i} at tail (caller ensures !full)
//   pop_i             : drop head entry (caller ensures !empty)
//   full_o, empty_o   : derived from the registered occupancy count
//   head_addr_o/data_o: oldest entry, the next one to drain
//   cam_addr_i        : lookup address
//   cam_hit_o/data_o  : any valid entry matches; data of the youngest match
module wbuf_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    input  logic [ADDR_W-1:0] cam_addr_i,
    output logic              cam_hit_o,
    output logic [DATA_W-1:0] cam_data_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + 1'b1;
            if (pop_i)  head_q <= head_q + 1'b1;
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Payload needs no reset: validity is defined purely by count_q.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];

    // Scan from oldest to youngest so a later match overrides an earlier one;
    // the head stays searchable while it is being drained.
    logic [PTR_W-1:0] idx;
    always_comb begin
        cam_hit_o  = 1'b0;
        cam_data_o = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr_q[idx] == cam_addr_i)) begin
                cam_hit_o  = 1'b1;
                cam_data_o = data_q[idx];
            end
        end
    end
endmodule

// File: rtl/cache_write_buffer.sv
// cache_write_buffer: posted writeback buffer between cache and main memory.
// Writebacks are acknowledged once queued and drained in the background; fetches
// are forwarded from the youngest queued match or else read from memory ahead of
// any queued writes (a write already on the bus always completes first).
//   clk, rst : clock, synchronous active-high reset (memory must reset with it)
//   cbus     : cache port (slave side), all outputs registered
//   mbus     : memory port (master side), all outputs registered
module cache_write_buffer #(
    parameter int DEPTH  = cache_pkg::WB_DEPTH,
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int DATA_W = cache_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    cwb_cache_if.slave   cbus,
    cwb_mem_if.master    mbus
);
    import cache_pkg::*;

    c_state_e          c_state_q;
    m_state_e          m_state_q;
    logic              rd_pend_q;
    logic              c_ready_q;
    logic [DATA_W-1:0] c_rdata_q;
    logic              mem_read_q, mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              full, empty, cam_hit;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data, cam_data;
    logic              push, pop, rd_take, rd_done;

    // Full uses the registered count only, so a pop in this cycle does not free
    // a slot for a push in the same cycle.
    assign push    = (c_state_q == C_IDLE) && cbus.c_write && !full;
    assign pop     = (m_state_q == M_WR) && mbus.mem_ready;
    assign rd_take = (m_state_q == M_IDLE) && rd_pend_q;
    assign rd_done = (m_state_q == M_RD) && mbus.mem_ready;

    wbuf_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_addr_i (cbus.c_addr),
        .push_data_i (cbus.c_wdata),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .cam_addr_i  (cbus.c_addr),
        .cam_hit_o   (cam_hit),
        .cam_data_o  (cam_data)
    );

    // Cache side. Requests seen in C_ACK are the one the cache is about to drop,
    // so they are ignored there to avoid a double enqueue. Write wins over read.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_state_q <= C_IDLE;
            c_ready_q <= 1'b0;
            c_rdata_q <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            case (c_state_q)
                C_IDLE: begin
                    if (cbus.c_write) begin
                        if (!full) begin
                            c_ready_q <= 1'b1;
                            c_state_q <= C_ACK;
                        end
                    end else if (cbus.c_read) begin
                        if (cam_hit) begin
                            c_rdata_q <= cam_data;
                            c_ready_q <= 1'b1;
                            c_state_q <= C_ACK;
                        end else begin
                            rd_pend_q <= 1'b1;
                            c_state_q <= C_RDMEM;
                        end
                    end
                end
                C_RDMEM: begin
                    if (rd_take) rd_pend_q <= 1'b0;
                    if (rd_done) begin
                        c_rdata_q <= mbus.mem_rdata;
                        c_ready_q <= 1'b1;
                        c_state_q <= C_ACK;
                    end
                end
                C_ACK: begin
                    c_ready_q <= 1'b0;
                    c_state_q <= C_IDLE;
                end
                default: c_state_q <= C_IDLE;
            endcase
        end
    end

    // Memory side. A pending fetch beats draining, but only at M_IDLE, so an
    // in-flight write is never aborted.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_state_q   <= M_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (m_state_q)
                M_IDLE: begin
                    if (rd_pend_q) begin
                        mem_read_q <= 1'b1;
                        mem_addr_q <= cbus.c_addr;
                        m_state_q  <= M_RD;
                    end else if (!empty) begin
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= head_addr;
                        mem_wdata_q <= head_data;
                        m_state_q   <= M_WR;
                    end
                end
                M_WR: begin
                    if (mbus.mem_ready) begin
                        mem_write_q <= 1'b0;
                        m_state_q   <= M_IDLE;
                    end
                end
                M_RD: begin
                    if (mbus.mem_ready) begin
                        mem_read_q <= 1'b0;
                        m_state_q  <= M_IDLE;
                    end
                end
                default: m_state_q <= M_IDLE;
            endcase
        end
    end

    assign cbus.c_ready    = c_ready_q;
    assign cbus.c_rdata    = c_rdata_q;
    assign mbus.mem_read   = mem_read_q;
    assign mbus.mem_write  = mem_write_q;
    assign mbus.mem_addr   = mem_addr_q;
    assign mbus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed bench for cache_write_buffer with a small memory responder model.
module tb_cache_write_buffer;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cwb_cache_if cif ();
    cwb_mem_if   mif ();

    cache_write_buffer dut (
        .clk  (clk),
        .rst  (rst),
        .cbus (cif),
        .mbus (mif)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Memory responder: fixed latency, answers only while n_resp < credit_lim
    // (credit_lim < 0 means unlimited). Unwritten lines read back as a pattern.
    logic [DATA_W-1:0] mem_model [logic [ADDR_W-1:0]];
    int credit_lim = -1;
    int n_resp = 0, n_rd = 0, n_wr = 0, lat_cnt = 0;
    logic [ADDR_W:0] log_q [$];   // {is_write, addr}

    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {32'hDEADBEEF, 68'h0, a};
    endfunction

    always @(posedge clk) begin
        mif.mem_ready <= 1'b0;
        if (rst) begin
            lat_cnt <= 0;
        end else if ((mif.mem_read || mif.mem_write) && !mif.mem_ready &&
                     (credit_lim < 0 || n_resp < credit_lim)) begin
            if (lat_cnt < 1) begin
                lat_cnt <= lat_cnt + 1;
            end else begin
                lat_cnt <= 0;
                mif.mem_ready <= 1'b1;
                n_resp++;
                if (mif.mem_write) begin
                    mem_model[mif.mem_addr] = mif.mem_wdata;
                    n_wr++;
                    log_q.push_back({1'b1, mif.mem_addr});
                end else begin
                    mif.mem_rdata <= rd_val(mif.mem_addr);
                    n_rd++;
                    log_q.push_back({1'b0, mif.mem_addr});
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cif.c_read = 1'b0;
        cif.c_write = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 300 && !cif.c_ready; i++) @(negedge clk);
        if (!cif.c_ready) chk({tag, "_timeout"}, 128'(0), 128'(1));
    endtask

    task automatic wait_drained(input string tag);
        int i;
        for (i = 0; i < 400; i++) begin
            if (dut.u_fifo.count_q == 0 && !mif.mem_write && !mif.mem_read) break;
            @(negedge clk);
        end
        if (i == 400) chk({tag, "_drain_timeout"}, 128'(0), 128'(1));
    endtask

    task automatic cwrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cif.c_write = 1'b1;
        cif.c_addr  = a;
        cif.c_wdata = d;
        tick(1);
        wait_ready("cwrite");
        cif.c_write = 1'b0;
    endtask

    task automatic cread(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        cif.c_read = 1'b1;
        cif.c_addr = a;
        tick(1);
        wait_ready("cread");
        d = cif.c_rdata;
        cif.c_read = 1'b0;
    endtask

    localparam logic [DATA_W-1:0] DA = 128'hAAAA_0001_0000_0000_0000_0000_0000_00A1;
    localparam logic [DATA_W-1:0] DB = 128'hBBBB_0002;
    localparam logic [DATA_W-1:0] DC = 128'hCCCC_0003;
    localparam logic [DATA_W-1:0] DD = 128'hDDDD_0004;
    localparam logic [DATA_W-1:0] DE = 128'hEEEE_0005;

    initial begin
        logic [DATA_W-1:0] d;
        int rd0, li;
        bit seen;

        rst = 1'b1;
        cif.c_read = 1'b0;
        cif.c_write = 1'b0;
        cif.c_addr = '0;
        cif.c_wdata = '0;
        tick(3);
        chk("rst_c_ready",   128'(cif.c_ready),   128'(0));
        chk("rst_c_rdata",   128'(cif.c_rdata),   128'(0));
        chk("rst_mem_read",  128'(mif.mem_read),  128'(0));
        chk("rst_mem_write", 128'(mif.mem_write), 128'(0));
        chk("rst_mem_addr",  128'(mif.mem_addr),  128'(0));
        chk("rst_mem_wdata", 128'(mif.mem_wdata), 128'(0));
        chk("rst_count",     128'(dut.u_fifo.count_q), 128'(0));
        rst = 1'b0;

        // 1: single write acknowledged next cycle, drained the cycle after.
        cif.c_write = 1'b1;
        cif.c_addr  = 28'h0000010;
        cif.c_wdata = DA;
        tick(1);
        chk("t1_ack", 128'(cif.c_ready), 128'(1));
        cif.c_write = 1'b0;
        tick(1);
        chk("t1_ack_one_cycle", 128'(cif.c_ready), 128'(0));
        chk("t1_mem_write", 128'(mif.mem_write), 128'(1));
        chk("t1_mem_addr",  128'(mif.mem_addr),  128'h10);
        chk("t1_mem_wdata", mif.mem_wdata, DA);
        wait_drained("t1");
        chk("t1_mem_data", rd_val(28'h10), DA);

        // 2 + 5: fill, stall when full, pop/push collision defers the push one cycle.
        do_reset();
        credit_lim = n_resp;
        for (int i = 0; i < 4; i++) cwrite(28'h100 + 28'(i), 128'(i + 1));
        tick(1);
        chk("t2_full_count", 128'(dut.u_fifo.count_q), 128'(4));
        cif.c_write = 1'b1;
        cif.c_addr  = 28'h200;
        cif.c_wdata = 128'h55;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (cif.c_ready) seen = 1'b1;
        end
        chk("t2_stall", 128'(seen), 128'(0));
        credit_lim = n_resp + 1;
        for (int i = 0; i < 50 && !mif.mem_ready; i++) tick(1);
        chk("t2_mem_ready_seen", 128'(mif.mem_ready), 128'(1));
        tick(1);
        chk("t5_push_refused", 128'(cif.c_ready), 128'(0));
        chk("t5_count_after_pop", 128'(dut.u_fifo.count_q), 128'(3));
        tick(1);
        chk("t5_push_accepted", 128'(cif.c_ready), 128'(1));
        chk("t2_count_back_4", 128'(dut.u_fifo.count_q), 128'(4));
        cif.c_write = 1'b0;
        credit_lim = -1;
        wait_drained("t2");
        chk("t2_last_drained", 128'(log_q[log_q.size()-1]), 128'({1'b1, 28'h200}));
        chk("t2_mem_data", rd_val(28'h200), 128'h55);

        // 3: duplicate addresses, read forwards youngest without touching memory.
        do_reset();
        credit_lim = n_resp;
        rd0 = n_rd;
        cwrite(28'h20, DB);
        cwrite(28'h20, DC);
        cread(28'h20, d);
        chk("t3_fwd_youngest", d, DC);
        chk("t3_no_mem_read_cnt", 128'(n_rd - rd0), 128'(0));
        chk("t3_no_mem_read", 128'(mif.mem_read), 128'(0));
        credit_lim = -1;
        wait_drained("t3");
        chk("t3_mem_youngest", rd_val(28'h20), DC);

        // 4: read miss during a drain waits for the write, then beats the queue.
        do_reset();
        credit_lim = n_resp;
        cwrite(28'h30, DD);
        cwrite(28'h50, DE);
        tick(1);
        chk("t4_wr30_inflight", 128'({mif.mem_write, mif.mem_addr}), 128'({1'b1, 28'h30}));
        li = log_q.size();
        cif.c_read = 1'b1;
        cif.c_addr = 28'h40;
        tick(3);
        chk("t4_read_waits", 128'(mif.mem_read), 128'(0));
        credit_lim = -1;
        wait_ready("t4");
        d = cif.c_rdata;
        cif.c_read = 1'b0;
        chk("t4_rdata", d, 128'hDEADBEEF_00000000_00000000_00000040);
        wait_drained("t4");
        chk("t4_order0", (log_q.size() > li)     ? 128'(log_q[li])     : '1, 128'({1'b1, 28'h30}));
        chk("t4_order1", (log_q.size() > li + 1) ? 128'(log_q[li + 1]) : '1, 128'({1'b0, 28'h40}));
        chk("t4_order2", (log_q.size() > li + 2) ? 128'(log_q[li + 2]) : '1, 128'({1'b1, 28'h50}));

        // 6: reset in the middle of a drain with three entries queued.
        do_reset();
        credit_lim = n_resp;
        cwrite(28'h60, DA);
        cwrite(28'h61, DB);
        cwrite(28'h62, DC);
        tick(1);
        chk("t6_in_wr", 128'(mif.mem_write), 128'(1));
        chk("t6_three_queued", 128'(dut.u_fifo.count_q), 128'(3));
        rst = 1'b1;
        tick(1);
        chk("t6_mem_write", 128'(mif.mem_write), 128'(0));
        chk("t6_mem_addr",  128'(mif.mem_addr),  128'(0));
        chk("t6_mem_wdata", 128'(mif.mem_wdata), 128'(0));
        chk("t6_c_ready",   128'(cif.c_ready),   128'(0));
        chk("t6_c_rdata",   128'(cif.c_rdata),   128'(0));
        chk("t6_count",     128'(dut.u_fifo.count_q), 128'(0));
        rst = 1'b0;
        credit_lim = -1;
        tick(4);
        chk("t6_idle_after", 128'({mif.mem_read, mif.mem_write}), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
